// File: rtl/ma_ext_pkg.sv
// Shared major-state encodings and opcode constants for the PDP-8/e memory
// address/data path, including the data-break B-states.
package ma_ext_pkg;

  typedef enum logic [4:0] {
    ST_F0 = 5'd0, ST_FW, ST_F1, ST_F2, ST_F3,
    ST_D0, ST_DW, ST_D1, ST_D2, ST_D3,
    ST_E0, ST_EW, ST_E1, ST_E2, ST_E3,
    ST_H0, ST_HW, ST_H1, ST_H2, ST_H3,
    ST_B0, ST_BW, ST_B1, ST_B2, ST_B3
  } major_state_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_TAD = 3'd1;
  localparam logic [2:0] OP_ISZ = 3'd2;
  localparam logic [2:0] OP_DCA = 3'd3;
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_IOT = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  localparam logic [11:0] WORD_ALL_ONES = 12'o7777;
  localparam logic [11:0] INSTR_RESET   = 12'o7000;
  localparam logic [11:0] INSTR_INT_JMS = 12'o4000;

endpackage

// File: rtl/ma_ext_ram.sv
// Single-port synchronous RAM, 12-bit words, one 4K bank per populated field.
// Accesses beyond the populated depth read 0 and never write.
module ram_ext
  import ma_ext_pkg::*;
#(
  parameter int FIELD_BITS = 3,
  parameter int MAX_FIELD  = 7
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [FIELD_BITS+11:0]   i_addr,
  input  logic [11:0]              i_wdata,
  output logic [11:0]              o_rdata
);

  localparam int DEPTH = (MAX_FIELD + 1) * 4096;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [FIELD_BITS+12:0] DEPTH_W = (FIELD_BITS + 13)'(DEPTH);

  logic [11:0] r_mem [DEPTH];
  logic        w_in_range;

  assign w_in_range = {1'b0, i_addr} < DEPTH_W;

  always_ff @(posedge clk) begin
    if (i_we && w_in_range) r_mem[i_addr[AW-1:0]] <= i_wdata;
    o_rdata <= w_in_range ? r_mem[i_addr[AW-1:0]] : 12'o0000;
  end

endmodule

// File: rtl/ma_ext.sv
// Memory address / memory data path for the PDP-8/e with extended memory:
// address and field muxing, auto-index, ISZ, JMS/DCA write-back, data break.
module ma_ext
  import ma_ext_pkg::*;
#(
  parameter int FIELD_BITS = 3,
  parameter int MAX_FIELD  = 7,
  parameter int AUTOINC_EN = 1,
  parameter int BREAK_EN   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [11:0]           pc,
  input  logic [11:0]           ac,
  input  logic [11:0]           sr,
  input  logic [4:0]            state,
  input  logic                  addr_loadd,
  input  logic                  depd,
  input  logic                  examd,
  input  logic                  int_in_prog,
  input  logic [FIELD_BITS-1:0] IF,
  input  logic [FIELD_BITS-1:0] DF,
  input  logic                  brk_req,
  input  logic [FIELD_BITS-1:0] brk_field,
  input  logic [11:0]           brk_addr,
  input  logic [11:0]           brk_din,
  input  logic                  brk_wr,
  input  logic                  brk_inc,
  output logic [11:0]           addr,
  output logic [FIELD_BITS-1:0] EMA,
  output logic [11:0]           ma,
  output logic [11:0]           mdout,
  output logic [11:0]           instruction,
  output logic                  isz_skip,
  output logic                  brk_ack,
  output logic [11:0]           brk_data_out,
  output logic                  brk_ovf,
  output logic                  nxm
);

  localparam logic [FIELD_BITS:0] FIELD_LIM = (FIELD_BITS + 1)'(MAX_FIELD);

  major_state_t          w_st;
  logic [2:0]            w_op, w_op_ew;
  logic                  w_ema_df, w_nxm, w_rd_cap, w_autoidx, w_we;
  logic [11:0]           w_rdata, w_rd, w_inc, w_wdata;
  logic                  w_unused_brk_req;

  logic [11:0]           r_ma, r_mdout, r_instruction, r_shadow, r_brk_data;
  logic [4:0]            r_page;
  logic [FIELD_BITS-1:0] r_brk_field;
  logic                  r_we, r_isz_skip, r_brk_ack, r_brk_ovf, r_nxm;

  // brk_req is arbitrated by the sequencer; B-states are honoured regardless.
  assign w_unused_brk_req = brk_req;

  assign w_st      = major_state_t'(state);
  assign w_op      = r_instruction[11:9];
  assign w_op_ew   = int_in_prog ? OP_JMS : w_op;
  assign w_ema_df  = (w_op <= OP_DCA) && r_instruction[8];
  assign w_nxm     = {1'b0, EMA} > FIELD_LIM;
  assign w_rd_cap  = w_st inside {ST_FW, ST_DW, ST_EW, ST_HW, ST_BW};
  assign w_autoidx = (AUTOINC_EN != 0) && (r_ma[11:3] == 9'd1);
  assign w_rd      = w_nxm ? 12'o0000 : w_rdata;
  assign w_inc     = r_mdout + 12'd1;
  assign w_we      = r_we && !w_nxm;

  // B0 presents the requester's target directly so the read can start there.
  always_comb begin
    addr = r_ma;
    EMA  = IF;
    if (w_st <= ST_F3) begin
      addr = pc;
    end else if (w_st == ST_B0) begin
      addr = brk_addr;
      EMA  = brk_field;
    end else if (w_st inside {[ST_BW:ST_B3]}) begin
      EMA  = r_brk_field;
    end else if ((w_st inside {[ST_E0:ST_E3]}) && w_ema_df) begin
      EMA  = DF;
    end
  end

  always_comb begin
    w_wdata = w_inc;
    case (w_st)
      ST_E1: begin
        if (w_op == OP_JMS)      w_wdata = pc;
        else if (w_op == OP_DCA) w_wdata = ac;
      end
      ST_H1:   w_wdata = sr;
      ST_B1:   if (!brk_inc) w_wdata = brk_din;
      default: w_wdata = w_inc;
    endcase
  end

  ram_ext #(
    .FIELD_BITS (FIELD_BITS),
    .MAX_FIELD  (MAX_FIELD)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  ({EMA, addr}),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ma          <= 12'o0000;
      r_mdout       <= 12'o0000;
      r_instruction <= INSTR_RESET;
      r_shadow      <= 12'o0000;
      r_brk_data    <= 12'o0000;
      r_page        <= 5'd0;
      r_brk_field   <= '0;
      r_we          <= 1'b0;
      r_isz_skip    <= 1'b0;
      r_brk_ack     <= 1'b0;
      r_brk_ovf     <= 1'b0;
      r_nxm         <= 1'b0;
    end else begin
      r_we      <= 1'b0;
      r_brk_ack <= 1'b0;
      if ((w_rd_cap || r_we) && w_nxm) r_nxm <= 1'b1;
      case (w_st)
        ST_F0: r_ma <= pc;
        ST_FW: begin
          r_mdout       <= w_rd;
          r_instruction <= w_rd;
        end
        ST_F2: r_page <= pc[11:7];
        ST_F3: begin
          if (w_op <= OP_JMP)
            r_ma <= {(r_instruction[7] ? r_page : 5'd0), r_instruction[6:0]};
          else
            r_ma <= pc;
        end
        ST_DW: begin
          r_mdout <= w_rd;
          r_we    <= w_autoidx;
        end
        ST_D2: r_ma <= w_autoidx ? w_inc : r_mdout;
        ST_EW: begin
          r_mdout <= w_rd;
          r_we    <= (w_op_ew == OP_ISZ) || (w_op_ew == OP_JMS) || (w_op_ew == OP_DCA);
          if (int_in_prog) begin
            r_instruction <= INSTR_INT_JMS;
            r_ma          <= 12'o0000;
          end
        end
        ST_E1: if ((w_op == OP_ISZ) && (r_mdout == WORD_ALL_ONES)) r_isz_skip <= 1'b1;
        ST_E3: r_isz_skip <= 1'b0;
        ST_HW: begin
          r_mdout <= w_rd;
          r_we    <= depd && !addr_loadd;
        end
        ST_H1: if (addr_loadd) r_ma <= sr;
        ST_H2: if (depd || examd) r_ma <= r_ma + 12'd1;
        ST_B0: begin
          if (BREAK_EN != 0) begin
            r_brk_field <= brk_field;
            r_ma        <= brk_addr;
            r_shadow    <= r_ma;
          end
        end
        ST_BW: begin
          r_mdout <= w_rd;
          r_we    <= (BREAK_EN != 0) && (brk_inc || brk_wr);
        end
        ST_B1: if (BREAK_EN != 0) r_brk_ovf <= brk_inc && (r_mdout == WORD_ALL_ONES);
        ST_B2: begin
          if (BREAK_EN != 0) begin
            r_brk_data <= brk_inc ? w_inc : r_mdout;
            r_brk_ack  <= 1'b1;
          end
        end
        ST_B3: if (BREAK_EN != 0) r_ma <= r_shadow;
        default: ;
      endcase
    end
  end

  assign ma           = r_ma;
  assign mdout        = r_mdout;
  assign instruction  = r_instruction;
  assign isz_skip     = r_isz_skip;
  assign nxm          = r_nxm;
  assign brk_ack      = (BREAK_EN != 0) && r_brk_ack;
  assign brk_data_out = (BREAK_EN != 0) ? r_brk_data : 12'o0000;
  assign brk_ovf      = (BREAK_EN != 0) && r_brk_ovf;

endmodule

// File: tb/tb_ma_ext.sv
// Directed bench for ma_ext: the sequencer's major states are driven one per
// cycle, memory is loaded and inspected through the data-break channel.
module tb_ma_ext;
  import ma_ext_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pc = '0, ac = '0, sr = '0;
  logic [4:0]  state = ST_H3;
  logic        addr_loadd = 0, depd = 0, examd = 0, int_in_prog = 0;
  logic [2:0]  IF = '0, DF = '0;
  logic        brk_req = 0;
  logic [2:0]  brk_field = '0;
  logic [11:0] brk_addr = '0, brk_din = '0;
  logic        brk_wr = 0, brk_inc = 0;
  logic [11:0] addr, ma, mdout, instruction, brk_data_out;
  logic [2:0]  EMA;
  logic        isz_skip, brk_ack, brk_ovf, nxm;

  int n_total = 0;
  int n_bad   = 0;
  int n_ack;
  logic [11:0] rd;

  ma_ext #(.FIELD_BITS(3), .MAX_FIELD(3), .AUTOINC_EN(1), .BREAK_EN(1)) dut (
    .clk(clk), .reset(reset), .pc(pc), .ac(ac), .sr(sr), .state(state),
    .addr_loadd(addr_loadd), .depd(depd), .examd(examd), .int_in_prog(int_in_prog),
    .IF(IF), .DF(DF), .brk_req(brk_req), .brk_field(brk_field), .brk_addr(brk_addr),
    .brk_din(brk_din), .brk_wr(brk_wr), .brk_inc(brk_inc), .addr(addr), .EMA(EMA),
    .ma(ma), .mdout(mdout), .instruction(instruction), .isz_skip(isz_skip),
    .brk_ack(brk_ack), .brk_data_out(brk_data_out), .brk_ovf(brk_ovf), .nxm(nxm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  task automatic step(input logic [4:0] s);
    state = s;
    @(posedge clk);
    #1;
    if (brk_ack) n_ack++;
  endtask

  task automatic brk_cycle(input logic [2:0] f, input logic [11:0] a,
                           input logic wr, input logic inc, input logic [11:0] d);
    brk_req = 1; brk_field = f; brk_addr = a; brk_wr = wr; brk_inc = inc; brk_din = d;
    n_ack = 0;
    step(ST_B0);
    brk_req = 0;
    step(ST_BW); step(ST_B1); step(ST_B2); step(ST_B3);
    brk_wr = 0; brk_inc = 0;
  endtask

  task automatic mem_wr(input logic [2:0] f, input logic [11:0] a, input logic [11:0] d);
    brk_cycle(f, a, 1'b1, 1'b0, d);
  endtask

  task automatic mem_rd(input logic [2:0] f, input logic [11:0] a, output logic [11:0] d);
    brk_cycle(f, a, 1'b0, 1'b0, 12'o0);
    d = brk_data_out;
  endtask

  task automatic fetch(input logic [11:0] p);
    pc = p;
    step(ST_F0); step(ST_FW); step(ST_F1); step(ST_F2); step(ST_F3);
  endtask

  task automatic defer_cycle();
    step(ST_D0); step(ST_DW); step(ST_D1); step(ST_D2); step(ST_D3);
  endtask

  task automatic panel(input logic [11:0] s, input logic ld, input logic dep, input logic ex);
    sr = s; addr_loadd = ld; depd = dep; examd = ex;
    step(ST_H0); step(ST_HW); step(ST_H1); step(ST_H2); step(ST_H3);
    addr_loadd = 0; depd = 0; examd = 0;
  endtask

  initial begin
    step(ST_H3); step(ST_H3);
    check("rst_ma", ma, 12'o0000);
    check("rst_instruction", instruction, 12'o7000);
    check("rst_mdout", mdout, 12'o0000);
    check("rst_isz_skip", isz_skip, 0);
    check("rst_brk_ack", brk_ack, 0);
    check("rst_brk_data", brk_data_out, 12'o0000);
    check("rst_brk_ovf", brk_ovf, 0);
    check("rst_nxm", nxm, 0);
    reset = 0;
    step(ST_H3);

    // Fetch from field 2, current-page operand
    mem_wr(3'd2, 12'o0200, 12'o1234);
    IF = 3'd2;
    pc = 12'o0200;
    step(ST_F0); step(ST_FW);
    check("fetch_instruction", instruction, 12'o1234);
    step(ST_F1); step(ST_F2); step(ST_F3);
    check("fetch_ma_f3", ma, 12'o0234);

    // Auto-index: TAD I 10 with 0010 = 0477
    IF = 3'd0; DF = 3'd3;
    mem_wr(3'd0, 12'o0010, 12'o0477);
    mem_wr(3'd0, 12'o0100, 12'o1410);
    fetch(12'o0100);
    check("autoidx_ma_f3", ma, 12'o0010);
    defer_cycle();
    check("autoidx_ma_d2", ma, 12'o0500);
    state = ST_E0; #1;
    check("autoidx_ema_df", EMA, 3'd3);
    @(posedge clk); #1;
    step(ST_EW); step(ST_E1); step(ST_E2); step(ST_E3);
    mem_rd(3'd0, 12'o0010, rd);
    check("autoidx_mem", rd, 12'o0500);

    // ISZ direct on 7777
    DF = 3'd0;
    mem_wr(3'd0, 12'o0050, 12'o7777);
    mem_wr(3'd0, 12'o0101, 12'o2050);
    fetch(12'o0101);
    check("isz_ma", ma, 12'o0050);
    state = ST_E0; #1;
    check("isz_ema_if", EMA, 3'd0);
    @(posedge clk); #1;
    step(ST_EW); step(ST_E1);
    check("isz_skip_e2", isz_skip, 1);
    step(ST_E2);
    check("isz_skip_e3", isz_skip, 1);
    step(ST_E3);
    check("isz_skip_clr", isz_skip, 0);
    mem_rd(3'd0, 12'o0050, rd);
    check("isz_mem_wrap", rd, 12'o0000);
    fetch(12'o0101);
    step(ST_E0); step(ST_EW); step(ST_E1);
    check("isz_noskip", isz_skip, 0);
    step(ST_E2); step(ST_E3);
    mem_rd(3'd0, 12'o0050, rd);
    check("isz_mem_inc", rd, 12'o0001);

    // Break memory-increment overflow in field 1
    mem_wr(3'd1, 12'o0050, 12'o7777);
    brk_cycle(3'd1, 12'o0050, 1'b0, 1'b1, 12'o0);
    check("brk_ovf", brk_ovf, 1);
    check("brk_data_inc", brk_data_out, 12'o0000);
    check("brk_ack_count", n_ack, 1);
    check("brk_ma_restore", ma, 12'o0050);
    brk_cycle(3'd1, 12'o0050, 1'b0, 1'b1, 12'o0);
    check("brk_noovf", brk_ovf, 0);
    check("brk_data_inc2", brk_data_out, 12'o0001);

    // Interrupt JMS 0000
    pc = 12'o0123; int_in_prog = 1;
    step(ST_E0); step(ST_EW);
    check("int_instruction", instruction, 12'o4000);
    check("int_ma", ma, 12'o0000);
    int_in_prog = 0;
    step(ST_E1); step(ST_E2); step(ST_E3);
    mem_rd(3'd0, 12'o0000, rd);
    check("int_jms_mem", rd, 12'o0123);

    // DCA I into a non-existent field
    mem_wr(3'd0, 12'o0020, 12'o0300);
    mem_wr(3'd0, 12'o0102, 12'o3420);
    mem_wr(3'd1, 12'o0300, 12'o4444);
    mem_wr(3'd0, 12'o0300, 12'o2222);
    DF = 3'd5; ac = 12'o1111;
    fetch(12'o0102);
    defer_cycle();
    check("nxm_ma_d2", ma, 12'o0300);
    check("nxm_before", nxm, 0);
    state = ST_E0; #1;
    check("nxm_ema", EMA, 3'd5);
    @(posedge clk); #1;
    step(ST_EW);
    check("nxm_read_zero", mdout, 12'o0000);
    check("nxm_flag", nxm, 1);
    step(ST_E1); step(ST_E2); step(ST_E3);
    DF = 3'd0;
    mem_rd(3'd1, 12'o0300, rd);
    check("nxm_no_alias_wr", rd, 12'o4444);
    mem_rd(3'd0, 12'o0300, rd);
    check("nxm_no_if_wr", rd, 12'o2222);
    check("nxm_sticky", nxm, 1);

    // Front panel load / deposit / examine
    panel(12'o0777, 1, 0, 0);
    check("fp_load_ma", ma, 12'o0777);
    panel(12'o0005, 0, 1, 0);
    panel(12'o0005, 0, 1, 0);
    check("fp_dep_ma", ma, 12'o1001);
    mem_rd(3'd0, 12'o0777, rd);
    check("fp_mem_0777", rd, 12'o0005);
    mem_rd(3'd0, 12'o1000, rd);
    check("fp_mem_1000", rd, 12'o0005);
    panel(12'o7777, 1, 0, 0);
    panel(12'o0000, 0, 0, 1);
    check("fp_wrap_ma", ma, 12'o0000);

    reset = 1;
    step(ST_H3);
    reset = 0;
    check("nxm_reset", nxm, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
